// File: rtl/uart_pkg.sv
// Shared UART definitions: default word width, the arbiter state encoding, and an index helper.
package uart_pkg;

  localparam int UART_WORD_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STROBE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } arb_state_t;

  // Next index after idx in a ring of n entries.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NUM_REQ-1.
module rr_picker #(
  parameter int  NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_valid
);

  // cand_idx[k] is the requester at priority offset k from ptr; one spare bit absorbs the wrap.
  logic [IW-1:0] cand_idx [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum = {1'b0, ptr} + (IW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ))
                                                      : sum[IW-1:0];
    end
  endgenerate

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    // Scan from the lowest priority up so the last hit is the closest to ptr.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        grant_idx = cand_idx[k];
        any_valid = 1'b1;
      end
    end
    if (any_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ producers: captures the winner's word,
// runs the load/strobe/completion handshake with uart_tx, then re-arbitrates.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  WORD_WIDTH   = UART_WORD_WIDTH,
  parameter int  BUSY_TIMEOUT = 16,
  localparam int IW           = $clog2(NUM_REQ),
  localparam int CW           = $clog2(BUSY_TIMEOUT)
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_ready,
  output logic [WORD_WIDTH-1:0]         tx_data_in,
  output logic                          tx_data_valid,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  arb_state_t            state_reg, state_next;
  logic [IW-1:0]         rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]         grant_reg, grant_next;
  logic [WORD_WIDTH-1:0] data_reg, data_next;
  logic [CW-1:0]         cnt_reg, cnt_next;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic [IW-1:0]         ptr_after;
  logic [WORD_WIDTH-1:0] req_word [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
      assign req_word[gi] = req_data[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  // The requester just served drops to lowest priority.
  assign ptr_after = IW'(wrap_inc(32'(grant_reg), 32'(NUM_REQ)));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      data_reg   <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      grant_reg  <= grant_next;
      data_reg   <= data_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_next  = grant_reg;
    data_next   = data_reg;
    cnt_next    = cnt_reg;
    timeout_err = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (tx_ready && pick_any) begin
          data_next  = req_word[pick_idx];
          grant_next = pick_idx;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        state_next = S_STROBE;
      end
      S_STROBE: begin
        cnt_next   = '0;
        state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!tx_ready) begin
          state_next = S_WAIT_DONE;
        end else if (cnt_reg == CW'(BUSY_TIMEOUT - 1)) begin
          // uart_tx never accepted the strobe: give up on this word but keep rotation fair.
          timeout_err = 1'b1;
          rr_ptr_next = ptr_after;
          state_next  = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready) begin
          rr_ptr_next = ptr_after;
          state_next  = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Gated by rst_n so no accept can leak out while reset is held.
  assign req_ready     = (rst_n && state_reg == S_IDLE && tx_ready) ? pick_grant : '0;
  assign tx_data_in    = data_reg;
  assign grant_id      = grant_reg;
  assign tx_data_valid = (state_reg == S_STROBE);
  assign busy          = (state_reg != S_IDLE);

endmodule
